// File: rtl/l1_cache_assoc_controller.sv
// l1_cache_assoc_controller
// Set-associative write-back L1 cache controller. Resolves hits from the
// per-way compare vectors, picks a victim per set (first invalid way, else a
// per-set round-robin pointer), and runs multi-beat write-back and refill
// bursts to external memory while stalling the CPU.
// Optional feature: define L1_CACHE_PERF_CNT_EN to enable the saturating
// hit/miss performance counters; otherwise both counter ports read 0.
module l1_cache_assoc_controller #(
    parameter int WAYS       = 2,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4,
    localparam int WW = (WAYS > 2) ? $clog2(WAYS) : 1,
    localparam int SW = $clog2(SETS),
    localparam int BW = $clog2(LINE_WORDS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req,
    input  logic            req_we,
    input  logic [SW-1:0]   set_idx,
    input  logic [WAYS-1:0] way_valid,
    input  logic [WAYS-1:0] way_hit,
    input  logic [WAYS-1:0] way_dirty,
    input  logic            mem_ack,
    output logic            sram_cs,
    output logic            sram_we,
    output logic [WW-1:0]   sram_way,
    output logic [BW-1:0]   sram_word,
    output logic            tag_we,
    output logic            dirty_set,
    output logic            stall,
    output logic            mem_cs,
    output logic            mem_we,
    output logic            mem_wb,
    output logic [BW-1:0]   mem_word,
    output logic [31:0]     hit_count,
    output logic [31:0]     miss_count
);

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        WRITE_BACK,
        ALLOCATE
    } state_t;

    localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);

    state_t        state;
    state_t        state_next;
    logic [BW-1:0] beat;
    logic [WW-1:0] victim;
    logic [SW-1:0] miss_set;
    logic [WW-1:0] rr_ptr [SETS];

    logic          hit;
    logic [WW-1:0] hit_way;
    logic [WW-1:0] victim_sel;
    logic          victim_dirty;
    logic          last_ack;
    logic          compare_miss;

    assign hit          = |way_hit;
    assign last_ack     = mem_ack && (beat == LAST_BEAT);
    assign compare_miss = (state == COMPARE) && req && !hit;
    assign victim_dirty = way_valid[victim_sel] && way_dirty[victim_sel];

    // Lowest-index hitting way wins; multiple hits are tolerated silently
    always_comb begin
        hit_way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (way_hit[i]) begin
                hit_way = WW'(i);
            end
        end
    end

    // Victim choice: lowest invalid way, falling back to the set's round-robin pointer
    always_comb begin
        victim_sel = rr_ptr[set_idx];
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!way_valid[i]) begin
                victim_sel = WW'(i);
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and output decode; bursts always run to completion once started
    always_comb begin
        state_next = state;
        sram_cs    = 1'b0;
        sram_we    = 1'b0;
        sram_way   = victim;
        sram_word  = beat;
        tag_we     = 1'b0;
        dirty_set  = 1'b0;
        mem_cs     = 1'b0;
        mem_we     = 1'b0;
        mem_wb     = 1'b0;
        mem_word   = beat;
        case (state)
            IDLE: begin
                sram_cs = req;
                if (req) begin
                    state_next = COMPARE;
                end
            end
            COMPARE: begin
                sram_cs = req;
                if (!req) begin
                    state_next = IDLE;
                end else if (hit) begin
                    sram_way   = hit_way;
                    sram_we    = req_we;
                    dirty_set  = req_we;
                    state_next = IDLE;
                end else begin
                    sram_way   = victim_sel;
                    state_next = victim_dirty ? WRITE_BACK : ALLOCATE;
                end
            end
            WRITE_BACK: begin
                sram_cs = 1'b1;
                mem_cs  = 1'b1;
                mem_we  = 1'b1;
                mem_wb  = 1'b1;
                if (last_ack) begin
                    state_next = ALLOCATE;
                end
            end
            ALLOCATE: begin
                sram_cs = 1'b1;
                mem_cs  = 1'b1;
                sram_we = mem_ack;
                if (last_ack) begin
                    tag_we     = 1'b1;
                    state_next = COMPARE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // CPU is released only in the cycle a request hits in COMPARE
    always_comb begin
        stall = req && !((state == COMPARE) && hit);
    end

    // Beat counter: cleared on entering a burst, advanced by each memory ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat <= '0;
        end else if (state == COMPARE) begin
            beat <= '0;
        end else if ((state == WRITE_BACK || state == ALLOCATE) && mem_ack) begin
            beat <= beat + 1'b1;
        end
    end

    // Victim way and its set are captured on a miss and held for the bursts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            victim   <= '0;
            miss_set <= '0;
        end else if (compare_miss) begin
            victim   <= victim_sel;
            miss_set <= set_idx;
        end
    end

    // Round-robin pointers advance only when a refill finishes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SETS; i++) begin
                rr_ptr[i] <= '0;
            end
        end else if ((state == ALLOCATE) && last_ack) begin
            rr_ptr[miss_set] <= rr_ptr[miss_set] + 1'b1;
        end
    end

`ifdef L1_CACHE_PERF_CNT_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
    logic        recompare;

    // Saturating hit/miss counters; the hit after a refill is not counted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt   <= '0;
            miss_cnt  <= '0;
            recompare <= 1'b0;
        end else begin
            recompare <= (state == ALLOCATE) && last_ack;
            if ((state == COMPARE) && req && hit && !recompare && (hit_cnt != '1)) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (compare_miss && (miss_cnt != '1)) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end

    assign hit_count  = hit_cnt;
    assign miss_count = miss_cnt;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_l1_cache_assoc_controller.sv
// tb_l1_cache_assoc_controller
// Directed self-checking bench for the L1 cache controller (WAYS=2,
// SETS=64, LINE_WORDS=4). Inputs change on the falling edge, outputs are
// checked 1 time unit later.
module tb_l1_cache_assoc_controller;

`ifdef L1_CACHE_PERF_CNT_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    logic        clk;
    logic        rst;
    logic        req;
    logic        req_we;
    logic [5:0]  set_idx;
    logic [1:0]  way_valid;
    logic [1:0]  way_hit;
    logic [1:0]  way_dirty;
    logic        mem_ack;
    logic        sram_cs;
    logic        sram_we;
    logic [0:0]  sram_way;
    logic [1:0]  sram_word;
    logic        tag_we;
    logic        dirty_set;
    logic        stall;
    logic        mem_cs;
    logic        mem_we;
    logic        mem_wb;
    logic [1:0]  mem_word;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int errors;
    int checks;

    l1_cache_assoc_controller #(
        .WAYS(2),
        .SETS(64),
        .LINE_WORDS(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .req_we(req_we),
        .set_idx(set_idx),
        .way_valid(way_valid),
        .way_hit(way_hit),
        .way_dirty(way_dirty),
        .mem_ack(mem_ack),
        .sram_cs(sram_cs),
        .sram_we(sram_we),
        .sram_way(sram_way),
        .sram_word(sram_word),
        .tag_we(tag_we),
        .dirty_set(dirty_set),
        .stall(stall),
        .mem_cs(mem_cs),
        .mem_we(mem_we),
        .mem_wb(mem_wb),
        .mem_word(mem_word),
        .hit_count(hit_count),
        .miss_count(miss_count)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic r, input logic we, input logic [5:0] s,
                                 input logic [1:0] v, input logic [1:0] h,
                                 input logic [1:0] d, input logic a);
        @(negedge clk);
        req       = r;
        req_we    = we;
        set_idx   = s;
        way_valid = v;
        way_hit   = h;
        way_dirty = d;
        mem_ack   = a;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst       = 1'b1;
        req       = 1'b0;
        req_we    = 1'b0;
        set_idx   = '0;
        way_valid = '0;
        way_hit   = '0;
        way_dirty = '0;
        mem_ack   = 1'b0;

        // Reset state
        applyStimulus(0, 0, 6'd0, 2'b00, 2'b00, 2'b00, 0);
        checkOutput("rst_stall", stall, 0);
        checkOutput("rst_mem_cs", mem_cs, 0);
        checkOutput("rst_sram_cs", sram_cs, 0);
        checkOutput("rst_tag_we", tag_we, 0);
        checkOutput("rst_hit_count", hit_count, 0);
        checkOutput("rst_miss_count", miss_count, 0);
        req = 1'b1;
        #1;
        checkOutput("rst_stall_req", stall, 1);
        applyStimulus(0, 0, 6'd0, 2'b00, 2'b00, 2'b00, 0);
        rst = 1'b0;

        // Ack outside a burst is ignored
        applyStimulus(0, 0, 6'd0, 2'b00, 2'b00, 2'b00, 1);
        checkOutput("idle_ack_mem_cs", mem_cs, 0);

        // Load hit on way 1, set 3
        applyStimulus(1, 0, 6'd3, 2'b11, 2'b10, 2'b00, 0);
        checkOutput("ld_idle_stall", stall, 1);
        checkOutput("ld_idle_sram_cs", sram_cs, 1);
        applyStimulus(1, 0, 6'd3, 2'b11, 2'b10, 2'b00, 0);
        checkOutput("ld_cmp_stall", stall, 0);
        checkOutput("ld_cmp_way", sram_way, 1);
        checkOutput("ld_cmp_we", sram_we, 0);
        checkOutput("ld_cmp_dirty", dirty_set, 0);
        applyStimulus(0, 0, 6'd3, 2'b11, 2'b00, 2'b00, 0);
        checkOutput("ld_hit_count", hit_count, PERF * 1);

        // Store hit on way 0, set 3
        applyStimulus(1, 1, 6'd3, 2'b11, 2'b01, 2'b00, 0);
        checkOutput("st_idle_stall", stall, 1);
        checkOutput("st_idle_we", sram_we, 0);
        applyStimulus(1, 1, 6'd3, 2'b11, 2'b01, 2'b00, 0);
        checkOutput("st_cmp_stall", stall, 0);
        checkOutput("st_cmp_way", sram_way, 0);
        checkOutput("st_cmp_we", sram_we, 1);
        checkOutput("st_cmp_dirty", dirty_set, 1);
        applyStimulus(0, 0, 6'd3, 2'b11, 2'b00, 2'b00, 0);
        checkOutput("st_hit_count", hit_count, PERF * 2);
        checkOutput("st_idle_mem_cs", mem_cs, 0);

        // Clean miss on set 5, way 1 invalid -> refill into way 1
        applyStimulus(1, 0, 6'd5, 2'b01, 2'b00, 2'b00, 0);
        checkOutput("m1_idle_stall", stall, 1);
        applyStimulus(1, 0, 6'd5, 2'b01, 2'b00, 2'b00, 0);
        checkOutput("m1_cmp_stall", stall, 1);
        checkOutput("m1_cmp_mem_cs", mem_cs, 0);
        applyStimulus(1, 0, 6'd5, 2'b01, 2'b00, 2'b00, 0);
        checkOutput("m1_wait_mem_cs", mem_cs, 1);
        checkOutput("m1_wait_mem_we", mem_we, 0);
        checkOutput("m1_wait_sram_we", sram_we, 0);
        checkOutput("m1_wait_word", mem_word, 0);
        for (int b = 0; b < 4; b++) begin
            applyStimulus(1, 0, 6'd5, 2'b01, 2'b00, 2'b00, 1);
            checkOutput("m1_ref_mem_cs", mem_cs, 1);
            checkOutput("m1_ref_sram_we", sram_we, 1);
            checkOutput("m1_ref_way", sram_way, 1);
            checkOutput("m1_ref_sram_word", sram_word, b);
            checkOutput("m1_ref_mem_word", mem_word, b);
            checkOutput("m1_ref_tag_we", tag_we, (b == 3) ? 1 : 0);
            checkOutput("m1_ref_stall", stall, 1);
            if (b == 1) begin
                applyStimulus(1, 0, 6'd5, 2'b01, 2'b00, 2'b00, 0);
                checkOutput("m1_gap_mem_cs", mem_cs, 1);
                checkOutput("m1_gap_sram_we", sram_we, 0);
                checkOutput("m1_gap_word", mem_word, 2);
            end
        end
        applyStimulus(1, 0, 6'd5, 2'b11, 2'b10, 2'b00, 0);
        checkOutput("m1_recmp_stall", stall, 0);
        checkOutput("m1_recmp_way", sram_way, 1);
        checkOutput("m1_recmp_tag_we", tag_we, 0);
        applyStimulus(0, 0, 6'd5, 2'b11, 2'b00, 2'b00, 0);
        checkOutput("m1_hit_count", hit_count, PERF * 2);
        checkOutput("m1_miss_count", miss_count, PERF * 1);

        // Dirty miss on set 9, all valid, pointer 0, way 0 dirty
        applyStimulus(1, 1, 6'd9, 2'b11, 2'b00, 2'b01, 0);
        applyStimulus(1, 1, 6'd9, 2'b11, 2'b00, 2'b01, 0);
        checkOutput("m2_cmp_stall", stall, 1);
        for (int b = 0; b < 4; b++) begin
            applyStimulus(1, 1, 6'd9, 2'b11, 2'b00, 2'b01, 1);
            checkOutput("m2_wb_mem_cs", mem_cs, 1);
            checkOutput("m2_wb_mem_we", mem_we, 1);
            checkOutput("m2_wb_mem_wb", mem_wb, 1);
            checkOutput("m2_wb_sram_cs", sram_cs, 1);
            checkOutput("m2_wb_sram_we", sram_we, 0);
            checkOutput("m2_wb_way", sram_way, 0);
            checkOutput("m2_wb_word", mem_word, b);
            checkOutput("m2_wb_tag_we", tag_we, 0);
        end
        for (int b = 0; b < 4; b++) begin
            applyStimulus(1, 1, 6'd9, 2'b11, 2'b00, 2'b01, 1);
            checkOutput("m2_ref_mem_cs", mem_cs, 1);
            checkOutput("m2_ref_mem_we", mem_we, 0);
            checkOutput("m2_ref_mem_wb", mem_wb, 0);
            checkOutput("m2_ref_sram_we", sram_we, 1);
            checkOutput("m2_ref_way", sram_way, 0);
            checkOutput("m2_ref_word", sram_word, b);
            checkOutput("m2_ref_tag_we", tag_we, (b == 3) ? 1 : 0);
        end
        applyStimulus(1, 1, 6'd9, 2'b11, 2'b01, 2'b00, 0);
        checkOutput("m2_recmp_stall", stall, 0);
        checkOutput("m2_recmp_way", sram_way, 0);
        checkOutput("m2_recmp_we", sram_we, 1);
        checkOutput("m2_recmp_dirty", dirty_set, 1);
        applyStimulus(0, 0, 6'd9, 2'b11, 2'b00, 2'b00, 0);
        checkOutput("m2_hit_count", hit_count, PERF * 2);
        checkOutput("m2_miss_count", miss_count, PERF * 2);

        // Set 5 pointer is now 1: all-valid clean miss refills way 1, reset after 2nd ack
        applyStimulus(1, 0, 6'd5, 2'b11, 2'b00, 2'b00, 0);
        applyStimulus(1, 0, 6'd5, 2'b11, 2'b00, 2'b00, 0);
        checkOutput("m3_cmp_mem_cs", mem_cs, 0);
        applyStimulus(1, 0, 6'd5, 2'b11, 2'b00, 2'b00, 1);
        checkOutput("m3_ref0_way", sram_way, 1);
        checkOutput("m3_ref0_mem_wb", mem_wb, 0);
        applyStimulus(1, 0, 6'd5, 2'b11, 2'b00, 2'b00, 1);
        checkOutput("m3_ref1_word", mem_word, 1);
        applyStimulus(1, 0, 6'd5, 2'b11, 2'b00, 2'b00, 0);
        checkOutput("m3_pre_rst_mem_cs", mem_cs, 1);
        rst = 1'b1;
        #1;
        checkOutput("m3_rst_mem_cs", mem_cs, 0);
        checkOutput("m3_rst_tag_we", tag_we, 0);
        checkOutput("m3_rst_sram_we", sram_we, 0);
        checkOutput("m3_rst_stall", stall, 1);
        checkOutput("m3_rst_miss_count", miss_count, 0);
        applyStimulus(0, 0, 6'd5, 2'b11, 2'b00, 2'b00, 1);
        checkOutput("m3_rst_ack_mem_cs", mem_cs, 0);
        checkOutput("m3_rst_ack_tag_we", tag_we, 0);
        rst = 1'b0;

        // Set 9 pointer back at 0; drop req during refill
        applyStimulus(1, 0, 6'd9, 2'b11, 2'b00, 2'b00, 0);
        checkOutput("m4_idle_stall", stall, 1);
        applyStimulus(1, 0, 6'd9, 2'b11, 2'b00, 2'b00, 0);
        applyStimulus(1, 0, 6'd9, 2'b11, 2'b00, 2'b00, 1);
        checkOutput("m4_ref0_way", sram_way, 0);
        checkOutput("m4_ref0_mem_we", mem_we, 0);
        for (int b = 1; b < 4; b++) begin
            applyStimulus(0, 0, 6'd9, 2'b11, 2'b00, 2'b00, 1);
            checkOutput("m4_ref_mem_cs", mem_cs, 1);
            checkOutput("m4_ref_sram_we", sram_we, 1);
            checkOutput("m4_ref_word", sram_word, b);
            checkOutput("m4_ref_stall", stall, 0);
            checkOutput("m4_ref_tag_we", tag_we, (b == 3) ? 1 : 0);
        end
        applyStimulus(0, 0, 6'd9, 2'b11, 2'b01, 2'b00, 0);
        checkOutput("m4_cmp_stall", stall, 0);
        checkOutput("m4_cmp_sram_we", sram_we, 0);
        checkOutput("m4_cmp_sram_cs", sram_cs, 0);
        checkOutput("m4_cmp_mem_cs", mem_cs, 0);
        applyStimulus(0, 0, 6'd9, 2'b11, 2'b00, 2'b00, 0);
        checkOutput("m4_idle_sram_cs", sram_cs, 0);
        checkOutput("m4_idle_mem_cs", mem_cs, 0);
        checkOutput("m4_hit_count", hit_count, 0);
        checkOutput("m4_miss_count", miss_count, PERF * 1);

        // Normal hit still works afterwards
        applyStimulus(1, 0, 6'd9, 2'b11, 2'b01, 2'b00, 0);
        checkOutput("end_idle_stall", stall, 1);
        applyStimulus(1, 0, 6'd9, 2'b11, 2'b01, 2'b00, 0);
        checkOutput("end_cmp_stall", stall, 0);
        applyStimulus(0, 0, 6'd9, 2'b11, 2'b00, 2'b00, 0);
        checkOutput("end_hit_count", hit_count, PERF * 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
